// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor
// Purpose  : Bit-serial unsigned subtractor, LSB first, one bit per clock.
// Revision : 1.0 - initial release
// ============================================================================
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] minuend,
    input  logic [WIDTH-1:0] subtrahend,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] difference,
    output logic             borrow_out
);

    localparam int               CNT_W  = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic [CNT_W-1:0] r_cnt;
    logic             r_borrow;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_diff;
    logic             r_bout;

    logic             w_a;
    logic             w_b;
    logic             w_d;
    logic             w_borrow_next;
    logic             w_last;
    logic [WIDTH-1:0] w_res_next;

    // Single subtractor cell; shift form keeps WIDTH=1 legal.
    assign w_a           = r_a[0];
    assign w_b           = r_b[0];
    assign w_d           = w_a ^ w_b ^ r_borrow;
    assign w_borrow_next = (~w_a & w_b) | (~(w_a ^ w_b) & r_borrow);
    assign w_res_next    = (r_res >> 1) | (WIDTH'(w_d) << (WIDTH - 1));
    assign w_last        = (r_state == S_RUN) && (r_cnt == C_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start)  w_state_next = S_RUN;
            S_RUN:   if (w_last) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_a      <= '0;
            r_b      <= '0;
            r_res    <= '0;
            r_cnt    <= '0;
            r_borrow <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_diff   <= '0;
            r_bout   <= 1'b0;
        end else begin
            r_done <= w_last;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a      <= minuend;
                        r_b      <= subtrahend;
                        r_borrow <= 1'b0;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                    end
                end
                S_RUN: begin
                    r_res    <= w_res_next;
                    r_a      <= r_a >> 1;
                    r_b      <= r_b >> 1;
                    r_borrow <= w_borrow_next;
                    r_cnt    <= r_cnt + CNT_W'(1);
                    // Outputs change only here, so partial results never leak.
                    if (w_last) begin
                        r_diff <= w_res_next;
                        r_bout <= w_borrow_next;
                    end
                end
                S_DONE: begin
                    r_busy <= 1'b0;
                end
                default: begin
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign difference = r_diff;
    assign borrow_out = r_bout;

endmodule
`default_nettype wire
